// File: rtl/adc_reader_pkg.sv
// ============================================================================
//  Module      : adc_reader_pkg
//  Description : Shared FSM encoding and Modular ADC CSR constants for the
//                ADC sample reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_reader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_IRQ_EN   = 4'd1,
        ST_SEQ_RUN  = 4'd2,
        ST_WAIT_IRQ = 4'd3,
        ST_RD_REQ   = 4'd4,
        ST_RD_CAP   = 4'd5,
        ST_PUSH     = 4'd6,
        ST_IRQ_CLR  = 4'd7
    } state_t;

    localparam logic        SEQ_CMD        = 1'b0;
    localparam logic [6:0]  SS_IRQ_EN      = 7'h40;
    localparam logic [6:0]  SS_IRQ_STATUS  = 7'h41;
    localparam logic [31:0] SEQ_SINGLE_RUN = 32'h0000_0003;
    localparam logic [31:0] SS_IRQ_BIT     = 32'h0000_0001;

endpackage

`default_nettype wire

// File: rtl/adc_sample_reader_if.sv
// ============================================================================
//  Module      : adc_sample_reader_if
//  Description : ADC CSR bus (sequencer + sample store) and sample stream
//                bundle between the reader and the ADC IP / sample sink.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_sample_reader_if #(
    parameter int SAMPLE_W = 12
) ();

    logic                seq_address;
    logic                seq_write;
    logic [31:0]         seq_writedata;
    logic [6:0]          ss_address;
    logic                ss_read;
    logic                ss_write;
    logic [31:0]         ss_writedata;
    logic [31:0]         ss_readdata;
    logic                ss_irq;
    logic                sample_valid;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample_data;
    logic [5:0]          sample_slot;

    modport master (
        output seq_address, seq_write, seq_writedata,
        output ss_address, ss_read, ss_write, ss_writedata,
        input  ss_readdata, ss_irq,
        output sample_valid, sample_data, sample_slot,
        input  sample_ready
    );

    modport slave (
        input  seq_address, seq_write, seq_writedata,
        input  ss_address, ss_read, ss_write, ss_writedata,
        output ss_readdata, ss_irq,
        input  sample_valid, sample_data, sample_slot,
        output sample_ready
    );

endinterface

`default_nettype wire

// File: rtl/adc_sample_reader.sv
// ============================================================================
//  Module      : adc_sample_reader
//  Description : Avalon-MM initiator that arms the Modular ADC IRQ, runs
//                single-cycle sequences and streams the stored samples out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_reader
    import adc_reader_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int TIMEOUT   = 65535,
    parameter int SAMPLE_W  = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    adc_sample_reader_if.master bus
);

    localparam int              c_tmo_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
    localparam logic [5:0]      c_last_slot = 6'(NUM_SLOTS - 1);

    state_t                r_state;
    logic [5:0]            r_slot;
    logic [c_tmo_w-1:0]    r_tmo;
    logic                  r_cont;
    logic                  r_stop;
    logic                  r_done;
    logic                  r_timeout_err;

    logic                  r_seq_address;
    logic                  r_seq_write;
    logic [31:0]           r_seq_writedata;
    logic [6:0]            r_ss_address;
    logic                  r_ss_read;
    logic                  r_ss_write;
    logic [31:0]           r_ss_writedata;
    logic                  r_sample_valid;
    logic [SAMPLE_W-1:0]   r_sample_data;
    logic [5:0]            r_sample_slot;

    // A stop arriving in the same cycle as the IRQ clear still ends the run.
    logic                  w_stop_seen;
    assign w_stop_seen = r_stop | stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_slot          <= '0;
            r_tmo           <= '0;
            r_cont          <= 1'b0;
            r_stop          <= 1'b0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_seq_address   <= 1'b0;
            r_seq_write     <= 1'b0;
            r_seq_writedata <= '0;
            r_ss_address    <= '0;
            r_ss_read       <= 1'b0;
            r_ss_write      <= 1'b0;
            r_ss_writedata  <= '0;
            r_sample_valid  <= 1'b0;
            r_sample_data   <= '0;
            r_sample_slot   <= '0;
        end else begin
            r_seq_write <= 1'b0;
            r_ss_write  <= 1'b0;
            r_ss_read   <= 1'b0;
            r_done      <= 1'b0;

            if (stop && (r_state != ST_IDLE)) begin
                r_stop <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cont        <= continuous;
                        r_timeout_err <= 1'b0;
                        r_stop        <= 1'b0;
                        r_state       <= ST_IRQ_EN;
                    end
                end
                ST_IRQ_EN: begin
                    r_ss_write     <= 1'b1;
                    r_ss_address   <= SS_IRQ_EN;
                    r_ss_writedata <= SS_IRQ_BIT;
                    r_state        <= ST_SEQ_RUN;
                end
                ST_SEQ_RUN: begin
                    r_seq_write     <= 1'b1;
                    r_seq_address   <= SEQ_CMD;
                    r_seq_writedata <= SEQ_SINGLE_RUN;
                    r_slot          <= '0;
                    r_tmo           <= '0;
                    r_state         <= ST_WAIT_IRQ;
                end
                ST_WAIT_IRQ: begin
                    if (bus.ss_irq) begin
                        r_state <= ST_RD_REQ;
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                        if (r_tmo == c_tmo_last) begin
                            r_timeout_err <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= ST_IDLE;
                        end
                    end
                end
                ST_RD_REQ: begin
                    r_ss_read    <= 1'b1;
                    r_ss_address <= {1'b0, r_slot};
                    r_state      <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    r_sample_data  <= bus.ss_readdata[SAMPLE_W-1:0];
                    r_sample_slot  <= r_slot;
                    r_sample_valid <= 1'b1;
                    r_state        <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (bus.sample_ready) begin
                        r_sample_valid <= 1'b0;
                        if (r_slot == c_last_slot) begin
                            r_state <= ST_IRQ_CLR;
                        end else begin
                            r_slot  <= r_slot + 6'd1;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_IRQ_CLR: begin
                    r_ss_write     <= 1'b1;
                    r_ss_address   <= SS_IRQ_STATUS;
                    r_ss_writedata <= SS_IRQ_BIT;
                    if (r_cont && !w_stop_seen) begin
                        r_state <= ST_SEQ_RUN;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy              = (r_state != ST_IDLE);
    assign done              = r_done;
    assign timeout_err       = r_timeout_err;

    assign bus.seq_address   = r_seq_address;
    assign bus.seq_write     = r_seq_write;
    assign bus.seq_writedata = r_seq_writedata;
    assign bus.ss_address    = r_ss_address;
    assign bus.ss_read       = r_ss_read;
    assign bus.ss_write      = r_ss_write;
    assign bus.ss_writedata  = r_ss_writedata;
    assign bus.sample_valid  = r_sample_valid;
    assign bus.sample_data   = r_sample_data;
    assign bus.sample_slot   = r_sample_slot;

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_reader.sv
// ============================================================================
//  Module      : tb_adc_sample_reader
//  Description : Scoreboard bench for adc_sample_reader with a behavioural
//                Modular ADC responder and a stallable sample sink.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_sample_reader;

    localparam int NUM_SLOTS = 4;
    localparam int TIMEOUT   = 100;
    localparam int SAMPLE_W  = 12;

    localparam logic [7:0] c_ev_ss_wr  = 8'd1;
    localparam logic [7:0] c_ev_seq_wr = 8'd2;
    localparam logic [7:0] c_ev_ss_rd  = 8'd3;
    localparam logic [7:0] c_ev_sample = 8'd4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic continuous;
    logic stop;
    logic busy;
    logic done;
    logic timeout_err;

    logic r_ready;
    logic r_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] exp_q[$];

    int  done_seen  = 0;
    int  stall_seen = 0;
    int  seq_cnt    = 0;
    int  stall_cnt  = 0;
    int  irq_cd     = 0;
    int  wait_cyc   = 0;
    int  done_at    = -1;
    bit  stall_en   = 1'b0;
    bit  irq_auto   = 1'b1;
    bit  stop_plan  = 1'b0;
    bit  stop_done  = 1'b0;

    adc_sample_reader_if #(.SAMPLE_W(SAMPLE_W)) bus ();

    adc_sample_reader #(
        .NUM_SLOTS (NUM_SLOTS),
        .TIMEOUT   (TIMEOUT),
        .SAMPLE_W  (SAMPLE_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Sample store answers in the cycle its registered read strobe is up;
    // junk in the upper bits and when idle exposes bad slicing or timing.
    assign bus.ss_readdata  = bus.ss_read ? ((32'(bus.ss_address) * 32'h111) | 32'hABC0_0000)
                                          : 32'hFFFF_FABC;
    assign bus.ss_irq       = r_irq;
    assign bus.sample_ready = r_ready;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mk_ev(input logic [7:0] k, input logic [7:0] a, input logic [31:0] d);
        return {k, a, d};
    endfunction

    function automatic logic [31:0] exp_sample(input int s);
        return 32'((s * 'h111) & 'hFFF);
    endfunction

    task automatic observe(input logic [47:0] ev);
        if (exp_q.size() == 0) begin
            check_val("unexpected_event", 64'(ev), 64'(0));
        end else begin
            check_val("event", 64'(ev), 64'(exp_q.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ss_write)
                observe(mk_ev(c_ev_ss_wr, {1'b0, bus.ss_address}, bus.ss_writedata));
            if (bus.seq_write)
                observe(mk_ev(c_ev_seq_wr, {7'b0, bus.seq_address}, bus.seq_writedata));
            if (bus.ss_read)
                observe(mk_ev(c_ev_ss_rd, {1'b0, bus.ss_address}, 32'h0));
            if (bus.sample_valid && bus.sample_ready)
                observe(mk_ev(c_ev_sample, {2'b0, bus.sample_slot}, {20'b0, bus.sample_data}));
            if (bus.sample_valid && !bus.sample_ready) begin
                stall_seen++;
                check_val("stall_hold", 64'({bus.sample_slot, bus.sample_data}), 64'({6'd2, 12'h222}));
            end
            if (done) done_seen++;
        end
    end

    // ADC responder, sink ready and stop generation, all acting just after the edge.
    initial begin
        r_ready = 1'b1;
        r_irq   = 1'b0;
        stop    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && bus.sample_valid && bus.sample_slot == 6'd2 && stall_cnt < 5) begin
                r_ready = 1'b0;
                stall_cnt++;
            end else begin
                r_ready = 1'b1;
            end
            if (bus.ss_write && bus.ss_address == 7'h41) begin
                r_irq  = 1'b0;
                irq_cd = 0;
            end
            if (bus.seq_write) begin
                seq_cnt++;
                wait_cyc = 0;
                if (irq_auto) irq_cd = 20;
            end else begin
                wait_cyc++;
                if (irq_cd > 0) begin
                    irq_cd--;
                    if (irq_cd == 0) r_irq = 1'b1;
                end
            end
            if (done) done_at = wait_cyc;
            if (stop_plan && !stop_done && seq_cnt == 2 && bus.sample_valid && bus.sample_slot == 6'd1) begin
                stop      = 1'b1;
                stop_done = 1'b1;
            end else begin
                stop = 1'b0;
            end
        end
    end

    task automatic push_arm();
        exp_q.push_back(mk_ev(c_ev_ss_wr, 8'h40, 32'h1));
    endtask

    task automatic push_sweep();
        exp_q.push_back(mk_ev(c_ev_seq_wr, 8'h00, 32'h3));
        for (int s = 0; s < NUM_SLOTS; s++) begin
            exp_q.push_back(mk_ev(c_ev_ss_rd, 8'(s), 32'h0));
            exp_q.push_back(mk_ev(c_ev_sample, 8'(s), exp_sample(s)));
        end
        exp_q.push_back(mk_ev(c_ev_ss_wr, 8'h41, 32'h1));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (done_seen > base) break;
        end
        check_val({tag, "_done"}, 64'(done_seen > base), 64'(1));
        repeat (6) @(negedge clk);
        #1;
        check_val({tag, "_done_cnt"}, 64'(done_seen - base), 64'(1));
        check_val({tag, "_q_empty"}, 64'(exp_q.size()), 64'(0));
        check_val({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic check_outs_zero(input string tag);
        check_val({tag, "_ctrl"},
                  64'({busy, done, timeout_err, bus.seq_address, bus.seq_write, bus.ss_address,
                       bus.ss_read, bus.ss_write, bus.sample_valid, bus.sample_slot, bus.sample_data}),
                  64'(0));
        check_val({tag, "_wdata"}, {bus.seq_writedata, bus.ss_writedata}, 64'(0));
    endtask

    initial begin
        int base;
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs_zero("reset");
        rst = 1'b0;

        // Single sweep.
        base = done_seen;
        push_arm(); push_sweep();
        pulse_start();
        wait_done("single", base, 300);

        // Sink stalls five cycles on slot 2.
        stall_cnt = 0; stall_seen = 0; stall_en = 1'b1;
        base = done_seen;
        push_arm(); push_sweep();
        pulse_start();
        wait_done("stall", base, 300);
        check_val("stall_cycles", 64'(stall_seen), 64'(5));
        stall_en = 1'b0;

        // Continuous with stop during the second sweep.
        continuous = 1'b1; stop_plan = 1'b1; stop_done = 1'b0; seq_cnt = 0;
        base = done_seen;
        push_arm(); push_sweep(); push_sweep();
        pulse_start();
        continuous = 1'b0;
        wait_done("cont_stop", base, 600);
        check_val("cont_seq_writes", 64'(seq_cnt), 64'(2));
        stop_plan = 1'b0;

        // IRQ never arrives.
        irq_auto = 1'b0; done_at = -1;
        base = done_seen;
        push_arm();
        exp_q.push_back(mk_ev(c_ev_seq_wr, 8'h00, 32'h3));
        pulse_start();
        for (int i = 0; i < 300 && done_seen == base; i++) begin
            @(negedge clk); #1;
        end
        check_val("tmo_err_set", 64'(timeout_err), 64'(1));
        check_val("tmo_latency", 64'(done_at), 64'(TIMEOUT));
        wait_done("timeout", base, 10);
        check_val("tmo_err_sticky", 64'(timeout_err), 64'(1));
        irq_auto = 1'b1;
        base = done_seen;
        push_arm(); push_sweep();
        pulse_start();
        check_val("tmo_err_cleared", 64'(timeout_err), 64'(0));
        wait_done("after_tmo", base, 300);

        // Reset while a sample is held in PUSH.
        stall_cnt = 0; stall_en = 1'b1;
        push_arm(); push_sweep();
        pulse_start();
        for (int i = 0; i < 300 && !(bus.sample_valid && !bus.sample_ready); i++) begin
            @(negedge clk);
        end
        check_val("rst_in_push", 64'(bus.sample_valid && !bus.sample_ready), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check_outs_zero("rst_mid");
        exp_q.delete();
        stall_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        base = done_seen;
        push_arm(); push_sweep();
        pulse_start();
        wait_done("post_rst", base, 300);

        // Start while busy must not restart the sequence.
        base = done_seen;
        push_arm(); push_sweep();
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check_val("busy_mid", 64'(busy), 64'(1));
        pulse_start();
        wait_done("start_busy", base, 300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/adc_sample_reader.md
Name: adc_sample_reader

Overview:
- Avalon-MM initiator that drives the Modular ADC IP CSR responders: sequencer_csr and sample_store_csr.
- Arms IRQ, starts single-cycle sequences, waits for sample_store_irq, reads NUM_SLOTS samples, clears IRQ, streams samples out on a valid/ready port.
- Sits between the core's ADC peripheral registers and the ADC IP instance.

Parameters:
- NUM_SLOTS, 8, sequence slots read per sweep (1..64)
- TIMEOUT, 65535, clk cycles to wait for IRQ before error
- SAMPLE_W, 12, sample width taken from readdata[SAMPLE_W-1:0]

Ports:
- clk  in  1  system clock (same as ADC IP clock_clk)
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begin acquisition (ignored unless IDLE)
- continuous  in  1  sampled at start; 1 = re-arm after each sweep
- stop  in  1  pulse; finish current sweep then return IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on return to IDLE (normal or error)
- timeout_err  out  1  sticky; set on IRQ timeout, cleared by start
- seq_address  out  1  to sequencer_csr_address
- seq_write  out  1  to sequencer_csr_write
- seq_writedata  out  32  to sequencer_csr_writedata
- ss_address  out  7  to sample_store_csr_address
- ss_read  out  1  to sample_store_csr_read
- ss_write  out  1  to sample_store_csr_write
- ss_writedata  out  32  to sample_store_csr_writedata
- ss_readdata  in  32  from sample_store_csr_readdata
- ss_irq  in  1  from sample_store_irq_irq
- sample_valid  out  1  stream valid
- sample_ready  in  1  stream ready
- sample_data  out  SAMPLE_W  sample value
- sample_slot  out  6  slot index of sample_data

Behaviour:
- Reset: all outputs 0, state IDLE, slot counter 0, timeout counter 0, continuous latch 0, stop latch 0.
- All bus outputs are registered. Each write/read strobe lasts exactly one cycle. No waitrequest.
- Read latency is fixed at 1: ss_readdata is captured the cycle after ss_read.
- FSM:
  - IDLE: on start, latch continuous, clear timeout_err and stop latch -> IRQ_EN.
  - IRQ_EN: ss_write, addr 0x40, data 1 -> SEQ_RUN.
  - SEQ_RUN: seq_write, addr 0, data 0x3 (mode=single-cycle, run=1). Clear slot counter and timeout counter -> WAIT_IRQ.
  - WAIT_IRQ:
    - If ss_irq -> RD_REQ.
    - Else increment timeout counter. When it reaches TIMEOUT: set timeout_err, pulse done -> IDLE. No further bus accesses.
  - RD_REQ: ss_read, ss_address=slot -> RD_CAP.
  - RD_CAP: sample_data<=ss_readdata[SAMPLE_W-1:0], sample_slot<=slot, sample_valid<=1 -> PUSH.
  - PUSH: hold data and valid stable until sample_ready. On the handshake cycle, drop valid next cycle:
    - If slot==NUM_SLOTS-1 -> IRQ_CLR.
    - Else slot++ -> RD_REQ.
  - IRQ_CLR: ss_write, addr 0x41, data 1 (W1C).
    - If continuous and no stop latched -> SEQ_RUN.
    - Else pulse done -> IDLE.
- stop pulse in any non-IDLE state sets the stop latch. The current sweep always completes. stop in IDLE is ignored.
- start while busy is ignored.
- sample_ready high while sample_valid low has no effect.
- Reset mid-operation returns to IDLE immediately; the ADC IRQ may remain set and is cleared by the next sweep.
- Minimum sweep latency after IRQ: 3 cycles per sample with ready held high, plus 1 cycle for IRQ_CLR.

Decomposition:
- Package adc_reader_pkg:
  - state enum
  - CSR address constants: SEQ_CMD=0, SS_IRQ_EN=0x40, SS_IRQ_STATUS=0x41
  - SEQ_SINGLE_RUN=32'h3
- No sub-module; single FSM plus counters.

Test Plan:
- start, continuous=0, NUM_SLOTS=4, model asserts irq 20 cycles after run; readdata=slot*0x111 -> writes 0x40<=1 then seq 0<=3, reads addrs 0..3, stream 0x000,0x111,0x222,0x333, write 0x41<=1, single done pulse.
- Same, sample_ready low for 5 cycles on slot 2 -> valid/data/slot held stable for all 5 cycles; no extra ss_read issued.
- continuous=1, stop pulsed during second sweep's slot 1 -> exactly 2 full sweeps (8 samples, 2 seq writes), then done.
- TIMEOUT=100, irq never asserted -> timeout_err=1 and done exactly 100 cycles after WAIT_IRQ entry; next start clears timeout_err.
- rst asserted in PUSH -> all outputs 0 on the next edge. A subsequent start runs a clean sweep.
- start pulsed while busy -> no second IRQ_EN write; sequence unchanged.
